// File: rtl/rvv_backend_uop_queue.sv
// rvv_backend_uop_queue: multi-push / multi-pop circular FIFO between vector
// decode and dispatch. Up to PUSH_N uops are written per cycle and the POP_N
// oldest entries are presented combinationally from storage.
// Optional feature macro: RVV_UOPQ_ERR_EN adds a sticky err_o flag that records
// any illegal push/pop request (non-thermometer or beyond free/count).
module rvv_backend_uop_queue #(
  parameter int  DEPTH  = 16,
  parameter int  PUSH_N = 4,
  parameter int  POP_N  = 2,
  parameter type DATA_T = logic [31:0]
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [PUSH_N-1:0] push_i,
  input  DATA_T             datain_i [PUSH_N],
  output logic              full_o,
  output logic [PUSH_N-1:1] almost_full_o,
  input  logic [POP_N-1:0]  pop_i,
  output DATA_T             dataout_o [POP_N],
  output logic              empty_o,
  output logic [POP_N-1:1]  almost_empty_o
`ifdef RVV_UOPQ_ERR_EN
  ,
  output logic              err_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  DATA_T         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free_s;
  logic [CW-1:0] push_run_s, pop_run_s;
  logic [CW-1:0] np_s, nq_s;
  logic          push_extra_s, pop_extra_s;

  assign free_s = CW'(DEPTH) - count_q;

  // Length of the contiguous run of ones from bit 0 of push/pop, plus a flag for stray bits above a hole.
  always_comb begin
    logic push_open, pop_open;
    push_run_s   = {CW{1'b0}};
    push_extra_s = 1'b0;
    push_open    = 1'b1;
    for (int k = 0; k < PUSH_N; k++) begin
      if (push_i[k] && push_open) begin
        push_run_s = push_run_s + CW'(1);
      end else if (push_i[k]) begin
        push_extra_s = 1'b1;
      end else begin
        push_open = 1'b0;
      end
    end
    pop_run_s   = {CW{1'b0}};
    pop_extra_s = 1'b0;
    pop_open    = 1'b1;
    for (int k = 0; k < POP_N; k++) begin
      if (pop_i[k] && pop_open) begin
        pop_run_s = pop_run_s + CW'(1);
      end else if (pop_i[k]) begin
        pop_extra_s = 1'b1;
      end else begin
        pop_open = 1'b0;
      end
    end
  end

  // Clip accepted counts against pre-edge free/count and form next pointer/count state.
  always_comb begin
    if (push_run_s > free_s) begin
      np_s = free_s;
    end else begin
      np_s = push_run_s;
    end
    if (pop_run_s > count_q) begin
      nq_s = count_q;
    end else begin
      nq_s = pop_run_s;
    end
    wr_ptr_d = wr_ptr_q + np_s[AW-1:0];
    rd_ptr_d = rd_ptr_q + nq_s[AW-1:0];
    count_d  = count_q + np_s - nq_s;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: accepted ports land at consecutive slots from wr_ptr, wrapping naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_T'(0);
      end
    end else begin
      for (int k = 0; k < PUSH_N; k++) begin
        if (CW'(k) < np_s) begin
          mem_q[wr_ptr_q + AW'(k)] <= datain_i[k];
        end
      end
    end
  end

  // Read window: the POP_N oldest slots, shown even when stale.
  always_comb begin
    for (int k = 0; k < POP_N; k++) begin
      dataout_o[k] = mem_q[rd_ptr_q + AW'(k)];
    end
  end

  // Flow-control flags decoded from the registered count only.
  always_comb begin
    full_o  = (free_s == {CW{1'b0}});
    empty_o = (count_q == {CW{1'b0}});
    for (int i = 1; i < PUSH_N; i++) begin
      almost_full_o[i] = (free_s <= CW'(i));
    end
    for (int i = 1; i < POP_N; i++) begin
      almost_empty_o[i] = (count_q <= CW'(i));
    end
  end

`ifdef RVV_UOPQ_ERR_EN
  logic err_q, err_d;

  // Any illegal request this cycle sets the sticky error.
  always_comb begin
    err_d = err_q | push_extra_s | (push_run_s > free_s)
                  | pop_extra_s  | (pop_run_s > count_q);
  end

  // Sticky error register, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: doc/rvv_backend_uop_queue.md
# rvv_backend_uop_queue

Multi-push / multi-pop circular FIFO holding decoded uops between the vector decode stage and the dispatch stage. Accepts up to PUSH_N uops per cycle from decode and presents up to POP_N oldest uops per cycle to dispatch. Exposes the full/almost-full and empty/almost-empty flag vectors that both neighbours use for multi-entry flow control.

## Interface
- DEPTH, 16: number of entries; power of two, DEPTH > PUSH_N, DEPTH >= POP_N.
- PUSH_N, 4: push ports, equal to `NUM_DE_UOP.
- POP_N, 2: pop ports, equal to dispatch width.
- DATA_T, UOP_QUEUE_t: entry type.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- push  in  PUSH_N  per-port write request; legal patterns are thermometer from bit 0.
- datain  in  PUSH_N x DATA_T  write data; port k is written only if push[k] is accepted.
- full  out  1  high when free == 0.
- almost_full  out  PUSH_N-1 (bits PUSH_N-1:1)  bit i high when free <= i.
- pop  in  POP_N  per-port read request; legal patterns are thermometer from bit 0.
- dataout  out  POP_N x DATA_T  dataout[k] = entry at rd_ptr+k, combinational from storage.
- empty  out  1  high when count == 0.
- almost_empty  out  POP_N-1 (bits POP_N-1:1)  bit i high when count <= i.
- err  out  1  sticky illegal-request flag; present only with RVV_UOPQ_ERR_EN.

## Operation
- State: storage[DEPTH], wr_ptr and rd_ptr (log2 DEPTH bits, natural wrap), count (log2 DEPTH + 1 bits), free = DEPTH - count.
- Accepted push count np = length of the contiguous run of ones from push[0], clipped to free. Any push bit above a zero, or beyond free, is dropped.
- Accepted pop count nq = length of the contiguous run of ones from pop[0], clipped to count. Any excess or non-contiguous bit is ignored.
- Writes: storage[wr_ptr+k] <= datain[k] for k < np. Then wr_ptr += np, with modulo-DEPTH wrap.
- Reads: rd_ptr += nq. Entries are not cleared on pop.
- Count update: count <= count + np - nq.
- Simultaneous push and pop: np is clipped against the pre-edge free, and nq against the pre-edge count. Slots freed by this cycle's pop are not reusable this cycle. Data pushed this cycle is not poppable this cycle, so there is no fall-through.
- Ordering: strict FIFO across ports. Port k of a push is older than port k+1.
- Flags are combinational decodes of the registered count only. They never depend on push or pop inputs, so there is no combinational path from pop to full or from push to empty.
- Consumer contract: entry i is valid iff !(empty | (|almost_empty[i:1])). Producer contract: port i may push iff !(full | (|almost_full[i:1])).

## Timing
- Write-to-visible latency is 1 cycle. An entry pushed at edge N appears on dataout and clears empty after edge N.
- Pop takes effect at the edge. The next entries are presented in the following cycle.
- Reset (asynchronous, any time, including mid-burst):
  - wr_ptr = rd_ptr = count = 0 and storage = 0.
  - Outputs: empty=1, almost_empty all 1, full=0, almost_full all 0, dataout all 0, err=0.
  - In-flight push and pop in the reset cycle are discarded.
- Wrap-around: a multi-entry push or pop straddling index DEPTH-1 -> 0 is handled within a single cycle.
- Boundary cases:
  - Full: all push bits are dropped, and state changes only by the pop.
  - Empty: pop is ignored, and dataout shows stale storage.

## Configuration
- RVV_UOPQ_ERR_EN defined:
  - err port and a sticky error register exist.
  - err sets on the edge after any illegal request: non-thermometer push, push beyond free, non-thermometer pop, or pop beyond count.
  - err clears only on rst.
  - Dropping and clipping behaviour is unchanged.
- RVV_UOPQ_ERR_EN undefined: no err port and no error register. Illegal requests are silently clipped as above.

## Test plan
- Reset then push=4'b1111 with A..D.
  - Next cycle: count=4, empty=0, almost_empty[1]=0, dataout[0]=A, dataout[1]=B.
  - With pop=2'b11 applied: next cycle dataout[0]=C, dataout[1]=D.
- Fill to count=14, then push=4'b1111 with W..Z.
  - Only W and X are written, and count=16, full=1.
  - With RVV_UOPQ_ERR_EN: err=1 and it stays 1.
- Wrap case: set rd_ptr = wr_ptr = 14 with count=0, then push 4.
  - Entries land in slots 14, 15, 0 and 1.
  - Two pop=2'b11 cycles return them in order, ending with wr_ptr=rd_ptr=2.
- Simultaneous events: at count=16 (full), apply push=4'b0001 together with pop=2'b11.
  - Push is dropped, count=14, and almost_full[1] drops to 0 the next cycle.
- Non-thermometer inputs:
  - push=4'b0101 writes only port 0.
  - pop=2'b10 pops nothing.
  - err follows per the configuration.
- Reset mid-operation: assert rst asynchronously while count=9 with push and pop active.
  - Outputs reach their reset values immediately.
  - After release, the first push is visible at dataout[0].
